gpr_csr_file: RTL and testbench

GPR_CSR_FILE -- requirements
Module: gpr_csr_file

---
 rtl/gpr_csr_file.sv | 188 ++++++++++++++++++
 tb/tb_gpr_csr_file.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpr_csr_file.sv
// Integer register file with a small machine-mode CSR block (mhartid, mscratch, mcycle, minstret).
// Define REGFILE_BYPASS_EN to forward a same-cycle GPR write onto the read ports.
module gpr_csr_file #(
    parameter int XLEN    = 32,
    parameter int NREG    = 32,
    parameter int HART_ID = 0,
    localparam int AW     = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic [XLEN-1:0] rs1_value,
    output logic [XLEN-1:0] rs2_value,
    input  logic [AW-1:0]   rd,
    input  logic [XLEN-1:0] rd_value,
    input  logic            rd_we,
    input  logic            csr_valid,
    input  logic [1:0]      csr_op,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] csr_wdata,
    output logic [XLEN-1:0] csr_rdata,
    output logic            csr_illegal,
    input  logic            instret_inc
);

    localparam bit IS32 = (XLEN == 32);

    localparam logic [11:0] ADDR_MHARTID   = 12'hF14;
    localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
    localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
    localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
    localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
    localparam logic [11:0] ADDR_CYCLE     = 12'hC00;
    localparam logic [11:0] ADDR_INSTRET   = 12'hC02;
    localparam logic [11:0] ADDR_CYCLEH    = 12'hC80;
    localparam logic [11:0] ADDR_INSTRETH  = 12'hC82;

    localparam logic [1:0] OP_READ = 2'b00;
    localparam logic [1:0] OP_RW   = 2'b01;
    localparam logic [1:0] OP_RS   = 2'b10;
    localparam logic [1:0] OP_RC   = 2'b11;

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic [XLEN-1:0] mscratch_q, mscratch_d;
    logic [63:0]     mcycle_q, mcycle_d;
    logic [63:0]     minstret_q, minstret_d;

    logic            csr_known;
    logic            csr_ro;
    logic            csr_wr;
    logic            csr_commit;
    logic [XLEN-1:0] csr_old;
    logic [XLEN-1:0] csr_new;

    // Low-half write: on RV32 only bits 31:0 change, on RV64 the whole counter is replaced.
    function automatic logic [63:0] write_lo(input logic [63:0] old, input logic [XLEN-1:0] v);
        if (IS32) begin
            return {old[63:32], v[31:0]};
        end
        return 64'(v);
    endfunction

    function automatic logic [63:0] write_hi(input logic [63:0] old, input logic [XLEN-1:0] v);
        return {v[31:0], old[31:0]};
    endfunction

    function automatic logic [XLEN-1:0] gpr_read(input logic [AW-1:0] addr);
        logic [XLEN-1:0] val;
        val = (addr == '0) ? '0 : regs_q[addr];
`ifdef REGFILE_BYPASS_EN
        if (rd_we && (rd != '0) && (addr == rd)) begin
            val = rd_value;
        end
`endif
        return val;
    endfunction

    always_comb begin
        rs1_value = gpr_read(rs1);
        rs2_value = gpr_read(rs2);
    end

    always_comb begin
        regs_d = regs_q;
        if (rd_we && (rd != '0)) begin
            regs_d[rd] = rd_value;
        end
        regs_d[0] = '0;
    end

    // Address decode: which CSR is selected, whether it is read-only, and its current value.
    always_comb begin
        csr_known = 1'b0;
        csr_ro    = 1'b0;
        csr_old   = '0;
        case (csr_addr)
            ADDR_MHARTID: begin
                csr_known = 1'b1;
                csr_ro    = 1'b1;
                csr_old   = XLEN'(HART_ID);
            end
            ADDR_MSCRATCH: begin
                csr_known = 1'b1;
                csr_old   = mscratch_q;
            end
            ADDR_MCYCLE, ADDR_CYCLE: begin
                csr_known = 1'b1;
                csr_ro    = (csr_addr == ADDR_CYCLE);
                csr_old   = XLEN'(mcycle_q);
            end
            ADDR_MINSTRET, ADDR_INSTRET: begin
                csr_known = 1'b1;
                csr_ro    = (csr_addr == ADDR_INSTRET);
                csr_old   = XLEN'(minstret_q);
            end
            ADDR_MCYCLEH, ADDR_CYCLEH: begin
                if (IS32) begin
                    csr_known = 1'b1;
                    csr_ro    = (csr_addr == ADDR_CYCLEH);
                    csr_old   = XLEN'(mcycle_q[63:32]);
                end
            end
            ADDR_MINSTRETH, ADDR_INSTRETH: begin
                if (IS32) begin
                    csr_known = 1'b1;
                    csr_ro    = (csr_addr == ADDR_INSTRETH);
                    csr_old   = XLEN'(minstret_q[63:32]);
                end
            end
            default: begin
                csr_known = 1'b0;
            end
        endcase
    end

    // Set/clear with an all-zero mask is a pure read and must not trip the read-only check.
    always_comb begin
        csr_wr = (csr_op == OP_RW) ||
                 (((csr_op == OP_RS) || (csr_op == OP_RC)) && (csr_wdata != '0));
        case (csr_op)
            OP_RW:   csr_new = csr_wdata;
            OP_RS:   csr_new = csr_old | csr_wdata;
            OP_RC:   csr_new = csr_old & ~csr_wdata;
            OP_READ: csr_new = csr_old;
            default: csr_new = csr_old;
        endcase
        csr_commit  = csr_valid && csr_known && csr_wr && !csr_ro;
        csr_illegal = csr_valid && (!csr_known || (csr_wr && csr_ro));
        csr_rdata   = (csr_valid && csr_known) ? csr_old : '0;
    end

    // Full 64-bit increment carries across halves; a CSR write replaces the increment entirely.
    always_comb begin
        mscratch_d = mscratch_q;
        mcycle_d   = mcycle_q + 64'd1;
        minstret_d = minstret_q + {63'd0, instret_inc};
        if (csr_commit) begin
            case (csr_addr)
                ADDR_MSCRATCH:  mscratch_d = csr_new;
                ADDR_MCYCLE:    mcycle_d   = write_lo(mcycle_q, csr_new);
                ADDR_MCYCLEH:   mcycle_d   = write_hi(mcycle_q, csr_new);
                ADDR_MINSTRET:  minstret_d = write_lo(minstret_q, csr_new);
                ADDR_MINSTRETH: minstret_d = write_hi(minstret_q, csr_new);
                default:        mscratch_d = mscratch_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            mscratch_q <= '0;
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            regs_q     <= regs_d;
            mscratch_q <= mscratch_d;
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
        end
    end

endmodule

// File: tb/tb_gpr_csr_file.sv
// Randomized bench for gpr_csr_file: behavioural model of registers and CSRs checked every cycle,
// preceded by directed sequences with hand-computed literal expectations.
module tb_gpr_csr_file;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int HART = 5;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [AW-1:0]   rs1, rs2, rd;
    logic [XLEN-1:0] rs1_value, rs2_value, rd_value;
    logic            rd_we;
    logic            csr_valid;
    logic [1:0]      csr_op;
    logic [11:0]     csr_addr;
    logic [XLEN-1:0] csr_wdata, csr_rdata;
    logic            csr_illegal;
    logic            instret_inc;

    always #5 clk = ~clk;

    gpr_csr_file #(.XLEN(XLEN), .NREG(NREG), .HART_ID(HART)) dut (
        .clk(clk), .rst(rst),
        .rs1(rs1), .rs2(rs2), .rs1_value(rs1_value), .rs2_value(rs2_value),
        .rd(rd), .rd_value(rd_value), .rd_we(rd_we),
        .csr_valid(csr_valid), .csr_op(csr_op), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
        .csr_rdata(csr_rdata), .csr_illegal(csr_illegal), .instret_inc(instret_inc)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit run   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_regs [NREG];
    logic [31:0] m_scratch;
    logic [63:0] m_cycle, m_instret;
    logic [63:0] nx_cycle, nx_instret;
    logic [31:0] nx_scratch;

    // {supported, read_only, value} for an address, straight from the CSR table
    function automatic logic [33:0] csr_peek(input logic [11:0] a);
        case (a)
            12'hF14: return {2'b11, 32'(HART)};
            12'h340: return {2'b10, m_scratch};
            12'hB00: return {2'b10, m_cycle[31:0]};
            12'hB80: return {2'b10, m_cycle[63:32]};
            12'hB02: return {2'b10, m_instret[31:0]};
            12'hB82: return {2'b10, m_instret[63:32]};
            12'hC00: return {2'b11, m_cycle[31:0]};
            12'hC80: return {2'b11, m_cycle[63:32]};
            12'hC02: return {2'b11, m_instret[31:0]};
            12'hC82: return {2'b11, m_instret[63:32]};
            default: return 34'h0;
        endcase
    endfunction

    function automatic bit wants_write();
        return (csr_op == 2'b01) || (csr_op[1] && (csr_wdata != 32'h0));
    endfunction

    function automatic logic [31:0] exp_gpr(input logic [AW-1:0] a);
        if (a == '0) return 32'h0;
        if (BYP && rd_we && (rd == a)) return rd_value;
        return m_regs[a];
    endfunction

    always_comb begin
        logic [33:0] p;
        logic [31:0] nv;
        p          = csr_peek(csr_addr);
        nv         = (csr_op == 2'b01) ? csr_wdata :
                     (csr_op == 2'b10) ? (p[31:0] | csr_wdata) : (p[31:0] & ~csr_wdata);
        nx_cycle   = m_cycle + 64'd1;
        nx_instret = m_instret + 64'(instret_inc);
        nx_scratch = m_scratch;
        if (csr_valid && p[33] && !p[32] && wants_write()) begin
            case (csr_addr)
                12'h340: nx_scratch = nv;
                12'hB00: nx_cycle   = {m_cycle[63:32], nv};
                12'hB80: nx_cycle   = {nv, m_cycle[31:0]};
                12'hB02: nx_instret = {m_instret[63:32], nv};
                12'hB82: nx_instret = {nv, m_instret[31:0]};
                default: nx_scratch = m_scratch;
            endcase
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) m_regs[i] <= 32'h0;
            m_scratch <= 32'h0;
            m_cycle   <= 64'h0;
            m_instret <= 64'h0;
        end else begin
            if (rd_we && (rd != '0)) m_regs[rd] <= rd_value;
            m_scratch <= nx_scratch;
            m_cycle   <= nx_cycle;
            m_instret <= nx_instret;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic [33:0] p;
        if (run) begin
            p = csr_peek(csr_addr);
            check("rs1_value", 64'(rs1_value), 64'(exp_gpr(rs1)));
            check("rs2_value", 64'(rs2_value), 64'(exp_gpr(rs2)));
            check("csr_rdata", 64'(csr_rdata), (csr_valid && p[33]) ? 64'(p[31:0]) : 64'h0);
            check("csr_illegal", 64'(csr_illegal),
                  64'(csr_valid && (!p[33] || (p[32] && wants_write()))));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic csr(input logic v, input logic [1:0] op, input logic [11:0] a, input logic [31:0] w);
        csr_valid = v;
        csr_op    = op;
        csr_addr  = a;
        csr_wdata = w;
    endtask

    logic [11:0] addrs [14] = '{12'hF14, 12'h340, 12'hB00, 12'hB02, 12'hB80, 12'hB82, 12'hC00,
                                12'hC02, 12'hC80, 12'hC82, 12'h7C0, 12'h341, 12'hB01, 12'h000};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        rs1 = '0; rs2 = '0; rd = '0; rd_value = '0; rd_we = 1'b0;
        instret_inc = 1'b0;
        csr(1'b0, 2'b00, 12'h000, 32'h0);
        step();
        step();
        run = 1'b1;

        // reset state
        csr(1'b1, 2'b00, 12'hB00, 32'h0);
        rs1 = 5'd5;
        @(negedge clk);
        check("reset_mcycle", 64'(csr_rdata), 64'h0);
        check("reset_x5", 64'(rs1_value), 64'h0);
        step();
        rst = 1'b0;
        @(negedge clk);
        check("mcycle_before_edge", 64'(csr_rdata), 64'h0);
        step();
        @(negedge clk);
        check("mcycle_first_edge", 64'(csr_rdata), 64'h1);

        // GPR write/read and x0
        step();
        csr(1'b0, 2'b00, 12'h000, 32'h0);
        rd_we = 1'b1; rd = 5'd5; rd_value = 32'hDEADBEEF;
        step();
        rd_we = 1'b0; rs1 = 5'd5;
        @(negedge clk);
        check("x5_read", 64'(rs1_value), 64'hDEADBEEF);
        check("idle_rdata", 64'(csr_rdata), 64'h0);
        step();
        rd_we = 1'b1; rd = 5'd0; rd_value = 32'h1234;
        step();
        rd_we = 1'b0; rs2 = 5'd0;
        @(negedge clk);
        check("x0_read", 64'(rs2_value), 64'h0);

        // same-cycle write/read of x7
        step();
        rd_we = 1'b1; rd = 5'd7; rs1 = 5'd7; rd_value = 32'hA5;
        @(negedge clk);
        check("bypass_x7", 64'(rs1_value), BYP ? 64'hA5 : 64'h0);
        step();
        rd_we = 1'b0;
        @(negedge clk);
        check("x7_after", 64'(rs1_value), 64'hA5);

        // mscratch RW / RS / RC
        step(); csr(1'b1, 2'b01, 12'h340, 32'hF0F0);
        @(negedge clk); check("mscratch_rw", 64'(csr_rdata), 64'h0);
        step(); csr(1'b1, 2'b10, 12'h340, 32'h000F);
        @(negedge clk); check("mscratch_rs", 64'(csr_rdata), 64'hF0F0);
        step(); csr(1'b1, 2'b11, 12'h340, 32'h00F0);
        @(negedge clk); check("mscratch_rc", 64'(csr_rdata), 64'hF0FF);
        step(); csr(1'b1, 2'b00, 12'h340, 32'h0);
        @(negedge clk); check("mscratch_final", 64'(csr_rdata), 64'hF00F);

        // mcycle low-half wrap carries into mcycleh
        step(); csr(1'b1, 2'b01, 12'hB00, 32'hFFFFFFFF);
        step(); csr(1'b1, 2'b00, 12'hB80, 32'h0);
        @(negedge clk); check("mcycleh_before", 64'(csr_rdata), 64'h0);
        step(); csr(1'b1, 2'b00, 12'hB00, 32'h0);
        @(negedge clk); check("mcycle_wrapped", 64'(csr_rdata), 64'h0);
        step(); csr(1'b1, 2'b00, 12'hB80, 32'h0);
        @(negedge clk); check("mcycleh_after", 64'(csr_rdata), 64'h1);

        // illegal accesses
        step(); csr(1'b1, 2'b01, 12'hC00, 32'h1234);
        @(negedge clk); check("ro_write_illegal", 64'(csr_illegal), 64'h1);
        step(); csr(1'b1, 2'b00, 12'hF14, 32'h0);
        @(negedge clk);
        check("mhartid", 64'(csr_rdata), 64'(HART));
        check("mhartid_legal", 64'(csr_illegal), 64'h0);
        step(); csr(1'b1, 2'b00, 12'h7C0, 32'h0);
        @(negedge clk);
        check("unknown_illegal", 64'(csr_illegal), 64'h1);
        check("unknown_rdata", 64'(csr_rdata), 64'h0);
        step(); csr(1'b1, 2'b10, 12'hC02, 32'h0);
        @(negedge clk); check("ro_rs_zero_legal", 64'(csr_illegal), 64'h0);
        step(); csr(1'b0, 2'b01, 12'h7C0, 32'h55);
        @(negedge clk);
        check("invalid_no_illegal", 64'(csr_illegal), 64'h0);
        check("invalid_rdata", 64'(csr_rdata), 64'h0);

        // minstret counts pulses, then reset mid-count
        step(); csr(1'b0, 2'b00, 12'h000, 32'h0);
        instret_inc = 1'b1;
        repeat (3) step();
        instret_inc = 1'b0;
        csr(1'b1, 2'b00, 12'hB02, 32'h0);
        @(negedge clk); check("minstret_3", 64'(csr_rdata), 64'h3);
        step();
        instret_inc = 1'b1; rs1 = 5'd5;
        step();
        #1;
        rst = 1'b1;
        #1;
        check("rst_minstret", 64'(csr_rdata), 64'h0);
        check("rst_x5", 64'(rs1_value), 64'h0);
        csr_addr = 12'hB00;
        #1;
        check("rst_mcycle", 64'(csr_rdata), 64'h0);
        step();
        rst = 1'b0;
        instret_inc = 1'b0;

        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            step();
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 399) == 0) rst = 1'b1;
            rd_we       = !rst && ($urandom_range(0, 1) == 1);
            rd          = AW'($urandom_range(0, NREG - 1));
            rd_value    = $urandom;
            rs1         = ($urandom_range(0, 3) == 0) ? rd : AW'($urandom_range(0, NREG - 1));
            rs2         = AW'($urandom_range(0, NREG - 1));
            instret_inc = ($urandom_range(0, 1) == 1);
            csr_valid   = ($urandom_range(0, 3) != 0);
            csr_op      = 2'($urandom_range(0, 3));
            csr_addr    = addrs[$urandom_range(0, 13)];
            case ($urandom_range(0, 7))
                0, 1:    csr_wdata = 32'h0;
                2:       csr_wdata = 32'hFFFFFFF0 + 32'($urandom_range(0, 15));
                default: csr_wdata = $urandom;
            endcase
        end

        step();
        run = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
